// File: rtl/phy_pkg.sv
// phy_pkg: symbol constants and receive-sync state encoding shared across the PHY lane.
package phy_pkg;
  localparam logic [7:0] COM_SYMBOL  = 8'hBC;
  localparam logic [7:0] IDLE_SYMBOL = 8'h7C;
  typedef enum logic [1:0] {RST = 2'd0, SEARCH = 2'd1, SYNC = 2'd2, ACTIVE = 2'd3} state_t;
endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// phy_rx_sync_ctrl_if: byte stream in from the deserializer, lock status and payload out.
interface phy_rx_sync_ctrl_if;
  logic       valid_in;
  logic [7:0] data_in;
  logic       sp_enable;
  logic       sync_active;
  logic       valid_out;
  logic [7:0] data_out;
  logic       com_detect;
  logic [7:0] err_count;
  modport master (output valid_in, data_in,
                  input  sp_enable, sync_active, valid_out, data_out, com_detect, err_count);
  modport slave  (input  valid_in, data_in,
                  output sp_enable, sync_active, valid_out, data_out, com_detect, err_count);
endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// phy_rx_sync_ctrl: acquires COM symbol lock, forwards payload bytes while locked, counts sync errors.
module phy_rx_sync_ctrl
  import phy_pkg::*;
#(
  parameter int COM_COUNT  = 4,
  parameter int LOSS_LIMIT = 3
) (
  input logic              clk_4f,
  input logic              reset,
  phy_rx_sync_ctrl_if.slave bus
);
  localparam logic [2:0] CC = 3'(COM_COUNT);
  localparam logic [2:0] LL = 3'(LOSS_LIMIT);
  state_t     state, state_n;
  logic [2:0] com_cnt, com_n, loss_cnt, loss_n;
  logic       valid_n, err_inc;
  logic [7:0] data_n;
  logic       com, payload;
  assign com     = bus.valid_in && bus.data_in == COM_SYMBOL;
  assign payload = bus.data_in != COM_SYMBOL && bus.data_in != IDLE_SYMBOL;
  always_comb begin
    state_n = state;
    com_n   = com_cnt;
    loss_n  = loss_cnt;
    valid_n = 1'b0;
    data_n  = bus.data_out;
    err_inc = 1'b0;
    case (state)
      RST: state_n = SEARCH;
      SEARCH: if (com) begin
        com_n   = 3'd1;
        state_n = SYNC;
      end
      SYNC: if (bus.valid_in) begin
        if (com) begin
          com_n   = (com_cnt + 3'd1 == CC) ? 3'd0 : com_cnt + 3'd1;
          loss_n  = (com_cnt + 3'd1 == CC) ? 3'd0 : loss_cnt;
          state_n = (com_cnt + 3'd1 == CC) ? ACTIVE : SYNC;
        end else begin
          com_n   = 3'd0;
          state_n = SEARCH;
          err_inc = 1'b1;
        end
      end
      ACTIVE: if (bus.valid_in) begin
        loss_n  = 3'd0;
        valid_n = payload;
        data_n  = payload ? bus.data_in : bus.data_out;
      end else begin
        loss_n  = (loss_cnt + 3'd1 == LL) ? 3'd0 : loss_cnt + 3'd1;
        state_n = (loss_cnt + 3'd1 == LL) ? SEARCH : ACTIVE;
        err_inc = loss_cnt + 3'd1 == LL;
      end
      default: state_n = RST;
    endcase
  end
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state           <= RST;
      com_cnt         <= '0;
      loss_cnt        <= '0;
      bus.sp_enable   <= 1'b0;
      bus.sync_active <= 1'b0;
      bus.valid_out   <= 1'b0;
      bus.data_out    <= '0;
      bus.com_detect  <= 1'b0;
      bus.err_count   <= '0;
    end else begin
      state           <= state_n;
      com_cnt         <= com_n;
      loss_cnt        <= loss_n;
      bus.sp_enable   <= state_n != RST;
      bus.sync_active <= state_n == ACTIVE;
      bus.valid_out   <= valid_n;
      bus.data_out    <= data_n;
      bus.com_detect  <= com && state != RST;
      bus.err_count   <= bus.err_count + {7'd0, err_inc && bus.err_count != 8'hFF};
    end
  end
endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// tb_phy_rx_sync_ctrl: directed stimulus with a payload scoreboard drained by a monitor process.
module tb_phy_rx_sync_ctrl;
  import phy_pkg::*;
  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  int passed = 0;
  int total  = 0;
  int com_pulses = 0;
  int c0;
  logic [7:0] exp_q[$];
  phy_rx_sync_ctrl_if bus();
  phy_rx_sync_ctrl dut (.clk_4f(clk_4f), .reset(reset), .bus(bus));
  always #5 clk_4f = ~clk_4f;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic send(input logic v, input logic [7:0] d, input logic fwd);
    @(negedge clk_4f);
    bus.valid_in = v;
    bus.data_in  = d;
    if (fwd) exp_q.push_back(d);
    @(posedge clk_4f);
    #2;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_sp_enable"}, int'(bus.sp_enable), 0);
    chk({tag, "_sync_active"}, int'(bus.sync_active), 0);
    chk({tag, "_valid_out"}, int'(bus.valid_out), 0);
    chk({tag, "_data_out"}, int'(bus.data_out), 0);
    chk({tag, "_com_detect"}, int'(bus.com_detect), 0);
    chk({tag, "_err_count"}, int'(bus.err_count), 0);
  endtask
  always @(posedge clk_4f) begin
    #1;
    if (!reset) begin
      if (bus.com_detect) com_pulses++;
      if (bus.valid_out) begin
        if (exp_q.size() == 0) chk("valid_out_unexpected", int'(bus.valid_out), 0);
        else chk("scoreboard_data_out", int'(bus.data_out), int'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
    #1;
    chk("pre_edge_sp_enable", int'(bus.sp_enable), 0);
    @(posedge clk_4f);
    #2;
    chk("first_edge_sp_enable", int'(bus.sp_enable), 1);
    c0 = com_pulses;
    repeat (3) send(1'b1, COM_SYMBOL, 1'b0);
    chk("lock_3rd_sync_active", int'(bus.sync_active), 0);
    send(1'b1, COM_SYMBOL, 1'b0);
    chk("lock_4th_sync_active", int'(bus.sync_active), 1);
    chk("lock_com_pulses", com_pulses - c0, 4);
    c0 = com_pulses;
    send(1'b1, COM_SYMBOL, 1'b0);
    send(1'b1, IDLE_SYMBOL, 1'b0);
    chk("idle_valid_out", int'(bus.valid_out), 0);
    send(1'b1, 8'hA5, 1'b1);
    chk("a5_valid_out", int'(bus.valid_out), 1);
    chk("a5_data_out", int'(bus.data_out), 8'hA5);
    send(1'b1, 8'h3C, 1'b1);
    chk("3c_data_out", int'(bus.data_out), 8'h3C);
    chk("active_com_pulses", com_pulses - c0, 1);
    repeat (2) send(1'b0, 8'h00, 1'b0);
    chk("gap2_sync_active", int'(bus.sync_active), 1);
    chk("gap2_valid_out", int'(bus.valid_out), 0);
    send(1'b1, 8'h11, 1'b1);
    chk("11_data_out", int'(bus.data_out), 8'h11);
    repeat (2) send(1'b0, 8'h00, 1'b0);
    chk("loss2_sync_active", int'(bus.sync_active), 1);
    send(1'b0, 8'h00, 1'b0);
    chk("loss3_sync_active", int'(bus.sync_active), 0);
    chk("loss3_err_count", int'(bus.err_count), 1);
    send(1'b1, COM_SYMBOL, 1'b0);
    send(1'b1, COM_SYMBOL, 1'b0);
    send(1'b1, 8'h55, 1'b0);
    chk("syncfail_err_count", int'(bus.err_count), 2);
    chk("syncfail_sync_active", int'(bus.sync_active), 0);
    chk("syncfail_sp_enable", int'(bus.sp_enable), 1);
    repeat (4) send(1'b1, COM_SYMBOL, 1'b0);
    chk("relock_sync_active", int'(bus.sync_active), 1);
    send(1'b1, 8'h5A, 1'b1);
    chk("5a_valid_out", int'(bus.valid_out), 1);
    #1;
    reset = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
    #1;
    chk("release_sp_enable", int'(bus.sp_enable), 0);
    chk("release_err_count", int'(bus.err_count), 0);
    repeat (3) send(1'b1, COM_SYMBOL, 1'b0);
    chk("reacq_3rd_sync_active", int'(bus.sync_active), 0);
    send(1'b1, COM_SYMBOL, 1'b0);
    chk("reacq_4th_sync_active", int'(bus.sync_active), 1);
    repeat (3) send(1'b0, 8'h00, 1'b0);
    chk("drop_err_count", int'(bus.err_count), 1);
    for (int i = 0; i < 100; i++) begin
      send(1'b1, COM_SYMBOL, 1'b0);
      send(1'b1, 8'h00, 1'b0);
    end
    chk("err_count_101", int'(bus.err_count), 101);
    for (int i = 0; i < 200; i++) begin
      send(1'b1, COM_SYMBOL, 1'b0);
      send(1'b1, 8'h00, 1'b0);
    end
    chk("err_count_sat", int'(bus.err_count), 255);
    send(1'b1, COM_SYMBOL, 1'b0);
    send(1'b1, 8'h00, 1'b0);
    chk("err_count_hold", int'(bus.err_count), 255);
    send(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Receive-side link synchronisation controller for the PCIe PHY lane. It sits directly after serial_paralelo in the clk_4f domain and consumes its byte stream (data_out/valid_out). It enables the deserializer, acquires symbol lock by counting consecutive COM symbols, and forwards payload bytes while in ACTIVE with COM/IDLE stripped. It detects loss of sync and counts sync errors.

Parameters:
COM_SYMBOL, 8'hBC, comma/alignment symbol value
IDLE_SYMBOL, 8'h7C, idle filler symbol, never forwarded
COM_COUNT, 4, consecutive COMs required to enter ACTIVE (2..7)
LOSS_LIMIT, 3, consecutive valid_in-low cycles in ACTIVE that drop sync (1..7)

Ports:
clk_4f  in  1  byte clock, shared with serial_paralelo parallel side
reset  in  1  asynchronous, active-high
valid_in  in  1  byte-valid from serial_paralelo valid_out
data_in  in  8  byte from serial_paralelo data_out
sp_enable  out  1  enable for the deserializer
sync_active  out  1  high while FSM is in ACTIVE (registered)
valid_out  out  1  payload byte valid
data_out  out  8  payload byte
com_detect  out  1  one-cycle pulse per COM sampled
err_count  out  8  saturating sync-error counter

Behaviour:
- All outputs and internal counters are registered. Reset asynchronously clears everything: state=RST, every output 0, com_cnt=0, loss_cnt=0, err_count=0.
- Sampling: a byte is "valid COM" when valid_in=1 and data_in==COM_SYMBOL.
- State RST: sp_enable=0. Exactly one clk_4f edge after reset release the FSM moves to SEARCH.
- State SEARCH: sp_enable=1. On a valid COM, set com_cnt=1 and go to SYNC. Otherwise stay. valid_in=0 is ignored.
- State SYNC, on a valid COM: com_cnt++.
  - When the incremented value equals COM_COUNT, go to ACTIVE, clear com_cnt and loss_cnt.
  - sync_active rises on the edge that enters ACTIVE, so it is visible the cycle after the COM_COUNT-th COM is sampled.
- State SYNC, on a valid non-COM byte: com_cnt=0, go to SEARCH, err_count++.
- State SYNC, valid_in=0: hold com_cnt and state.
- State ACTIVE, valid_in=1:
  - loss_cnt=0.
  - If data_in is neither COM_SYMBOL nor IDLE_SYMBOL: data_out<=data_in and valid_out<=1 on the same edge (latency one clk_4f).
  - COM or IDLE: valid_out<=0 and data_out holds its last value.
- State ACTIVE, valid_in=0:
  - valid_out<=0 and loss_cnt++.
  - On reaching LOSS_LIMIT: go to SEARCH, sync_active<=0, err_count++, loss_cnt=0.
- valid_out is never 1 outside ACTIVE. On the exit edge from ACTIVE, valid_out<=0.
- com_detect<=1 for one cycle for every valid COM sampled in SEARCH, SYNC or ACTIVE. It is never asserted in RST.
- err_count saturates at 8'hFF and never wraps. An increment request at 255 leaves it at 255.
- Simultaneous events: the state transition takes priority over data forwarding on the same edge.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge. On release the FSM restarts from RST and must re-acquire lock from scratch.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYMBOL and IDLE_SYMBOL constants, also used by the transmit path;
  - the 2-bit state encoding (RST=0, SEARCH=1, SYNC=2, ACTIVE=3).
- Single module; no sub-module is warranted. The saturating err_count is an inline always block.

Test Plan:
- Reset 2 cycles, release, then feed BC,BC,BC,BC with valid_in=1 -> sp_enable=1 from the 1st edge after release; sync_active=1 one cycle after the 4th BC; com_detect pulses 4 times; valid_out stays 0.
- From SEARCH feed BC,BC,55 -> FSM returns to SEARCH, err_count=1, sync_active and valid_out remain 0.
- In ACTIVE feed BC,7C,A5,3C back to back -> valid_out=1 only for A5 and 3C, each one cycle after its input, data_out=A5 then 3C; com_detect pulses once, for the BC.
- In ACTIVE deassert valid_in 2 cycles, then feed 11 -> stays ACTIVE and forwards 11. Next, deassert 3 cycles -> sync_active=0 after the 3rd, err_count increments by 1.
- Assert reset for 1 cycle while forwarding data -> all outputs 0 without a clock edge; sp_enable=0 for one cycle after release; 4 new BCs are required to relock.
- Force 300 SYNC failures (BC,00 repeated) -> err_count reaches 255 and holds at 255.
